fabric_frame_config_sequencer: RTL and testbench



---
 rtl/fabric_cfg_pkg.sv | 23 ++
 rtl/frame_strobe_decoder.sv | 25 ++
 rtl/fabric_frame_config_sequencer.sv | 176 +++++++++++++++++
 tb/tb_fabric_frame_config_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// Shared types and constants for the frame-based configuration sequencer.
// Header layout: [31] last frame, [15:8] column, [4:0] frame index.
package fabric_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        STROBE
    } cfg_state_t;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

    localparam int HDR_LAST_BIT  = 31;
    localparam int HDR_COL_MSB   = 15;
    localparam int HDR_COL_LSB   = 8;
    localparam int HDR_FRAME_MSB = 4;
    localparam int HDR_FRAME_LSB = 0;

    localparam int HDR_COL_W   = HDR_COL_MSB - HDR_COL_LSB + 1;
    localparam int HDR_FRAME_W = HDR_FRAME_MSB - HDR_FRAME_LSB + 1;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Combinational column/frame to one-hot strobe decode.
// Out-of-range addresses simply match no output bit.
module frame_strobe_decoder #(
    parameter int NumberOfCols    = 16,
    parameter int MaxFramesPerCol = 20,
    parameter int COL_W           = 8,
    parameter int FRAME_W         = 5
) (
    input  logic [COL_W-1:0]                        col,
    input  logic [FRAME_W-1:0]                      frame,
    input  logic                                    en,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe
);

    genvar gi, gj;
    generate
        for (gi = 0; gi < NumberOfCols; gi++) begin : g_col
            for (gj = 0; gj < MaxFramesPerCol; gj++) begin : g_frame
                assign FrameStrobe[gi*MaxFramesPerCol + gj] =
                    en && (col == COL_W'(gi)) && (frame == FRAME_W'(gj));
            end
        end
    endgenerate

endmodule

// File: rtl/fabric_frame_config_sequencer.sv
// Assembles one configuration frame across all tile rows from a word stream,
// then pulses a single column/frame strobe so the addressed tiles latch it.
module fabric_frame_config_sequencer
    import fabric_cfg_pkg::*;
#(
    parameter int NumberOfRows    = 16,
    parameter int FrameBitsPerRow = 32,
    parameter int NumberOfCols    = 16,
    parameter int MaxFramesPerCol = 20
) (
    input  logic                                    CLK,
    input  logic                                    reset,
    input  logic                                    s_valid,
    input  logic [FrameBitsPerRow-1:0]              s_data,
    output logic                                    s_ready,
    output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                    cfg_active,
    output logic                                    cfg_done,
    output logic                                    cfg_err
);

    localparam int ROW_W    = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam int STROBE_W = NumberOfCols * MaxFramesPerCol;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NumberOfRows - 1);

    cfg_state_t             state_reg, state_next;
    logic [ROW_W-1:0]       row_cnt_reg;
    logic [HDR_COL_W-1:0]   col_reg;
    logic [HDR_FRAME_W-1:0] frame_reg;
    logic                   last_reg;
    logic                   frame_ok_reg;
    logic [STROBE_W-1:0]    strobe_reg;
    logic [STROBE_W-1:0]    strobe_decoded;
    logic                   active_reg;
    logic                   done_reg;
    logic                   err_reg;

    logic                   accept;
    logic                   sync_hit;
    logic                   hdr_load;
    logic                   data_load;
    logic                   hdr_ok;
    logic [HDR_COL_W-1:0]   hdr_col;
    logic [HDR_FRAME_W-1:0] hdr_frame;

    assign s_ready   = (state_reg != STROBE);
    assign accept    = s_valid && s_ready;
    assign hdr_col   = s_data[HDR_COL_MSB:HDR_COL_LSB];
    assign hdr_frame = s_data[HDR_FRAME_MSB:HDR_FRAME_LSB];
    assign hdr_ok    = (int'(hdr_col) < NumberOfCols) && (int'(hdr_frame) < MaxFramesPerCol);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sync_hit   = 1'b0;
        hdr_load   = 1'b0;
        data_load  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept && (s_data == SYNC_WORD)) begin
                    sync_hit   = 1'b1;
                    state_next = HEADER;
                end
            end
            HEADER: begin
                if (accept) begin
                    hdr_load   = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    data_load = 1'b1;
                    if (row_cnt_reg == LAST_ROW) begin
                        state_next = STROBE;
                    end
                end
            end
            STROBE: begin
                state_next = last_reg ? IDLE : HEADER;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    frame_strobe_decoder #(
        .NumberOfCols   (NumberOfCols),
        .MaxFramesPerCol(MaxFramesPerCol),
        .COL_W          (HDR_COL_W),
        .FRAME_W        (HDR_FRAME_W)
    ) u_decoder (
        .col        (col_reg),
        .frame      (frame_reg),
        .en         (frame_ok_reg),
        .FrameStrobe(strobe_decoded)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            row_cnt_reg  <= '0;
            col_reg      <= '0;
            frame_reg    <= '0;
            last_reg     <= 1'b0;
            frame_ok_reg <= 1'b0;
            strobe_reg   <= '0;
            active_reg   <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            strobe_reg <= '0;
            done_reg   <= 1'b0;
            if (sync_hit) begin
                active_reg <= 1'b1;
                err_reg    <= 1'b0;
            end
            if (hdr_load) begin
                col_reg      <= hdr_col;
                frame_reg    <= hdr_frame;
                last_reg     <= s_data[HDR_LAST_BIT];
                frame_ok_reg <= hdr_ok;
                row_cnt_reg  <= '0;
                if (!hdr_ok) begin
                    err_reg <= 1'b1;
                end
            end
            // The strobe register is loaded on the final data word so it is
            // high exactly during the STROBE cycle.
            if (data_load) begin
                if (row_cnt_reg == LAST_ROW) begin
                    strobe_reg <= strobe_decoded;
                end else begin
                    row_cnt_reg <= row_cnt_reg + ROW_W'(1);
                end
            end
            if ((state_reg == STROBE) && last_reg) begin
                active_reg <= 1'b0;
                done_reg   <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NumberOfRows; gi++) begin : g_row
            // First data word of a frame lands in the top row.
            localparam logic [ROW_W-1:0] ROW_SLOT = ROW_W'(NumberOfRows - 1 - gi);
            logic [FrameBitsPerRow-1:0] row_reg;

            always_ff @(posedge CLK) begin
                if (reset) begin
                    row_reg <= '0;
                end else if (data_load && (row_cnt_reg == ROW_SLOT)) begin
                    row_reg <= s_data;
                end
            end

            assign FrameData[gi*FrameBitsPerRow +: FrameBitsPerRow] = row_reg;
        end
    endgenerate

    assign FrameStrobe = strobe_reg;
    assign cfg_active  = active_reg;
    assign cfg_done    = done_reg;
    assign cfg_err     = err_reg;

endmodule

// File: tb/tb_fabric_frame_config_sequencer.sv
// Self-checking bench: header decode table, hand-written corner sequences and
// randomized sessions checked against a word-stream parsing model.
module tb_fabric_frame_config_sequencer;
    import fabric_cfg_pkg::*;

    localparam int NR = 16;
    localparam int W  = 32;
    localparam int NC = 16;
    localparam int MF = 20;
    localparam int SW = NC * MF;
    localparam int FW = NR * W;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic          s_ready;
    logic [FW-1:0] FrameData;
    logic [SW-1:0] FrameStrobe;
    logic          cfg_active;
    logic          cfg_done;
    logic          cfg_err;

    fabric_frame_config_sequencer #(
        .NumberOfRows   (NR),
        .FrameBitsPerRow(W),
        .NumberOfCols   (NC),
        .MaxFramesPerCol(MF)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .cfg_active (cfg_active),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    int            strobe_bits[$];
    logic [FW-1:0] strobe_data[$];
    int            strobe_ready_hi = 0;
    int            done_cnt = 0;
    int            done_bad = 0;
    logic          prev_ready = 1'b1;
    logic [W-1:0]  words[NR];
    bit            model_err = 1'b0;

    function automatic int strobe_index(input logic [SW-1:0] v);
        int idx;
        idx = -2;
        if ($countones(v) == 1) begin
            for (int i = 0; i < SW; i++) begin
                if (v[i]) idx = i;
            end
        end
        return idx;
    endfunction

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if (FrameStrobe != '0) begin
            strobe_bits.push_back(strobe_index(FrameStrobe));
            strobe_data.push_back(FrameData);
            if (s_ready) strobe_ready_hi++;
        end
        if (cfg_done) begin
            done_cnt++;
            if (prev_ready || cfg_active) done_bad++;
        end
        prev_ready <= s_ready;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int max_gap);
        int   gap;
        logic acc;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            s_valid = 1'b0;
            s_data  = ($urandom_range(3, 0) == 0) ? SYNC_WORD : $urandom;
            step();
        end
        s_valid = 1'b1;
        s_data  = w;
        for (int t = 0; t < 8; t++) begin
            acc = s_ready;
            step();
            if (acc) begin
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        n_tests++;
        n_fail++;
        $display("FAIL handshake_timeout: word %h not accepted within 8 cycles", w);
    endtask

    task automatic run_frame(input logic [W-1:0] hdr, input bit ramp, input int gap, input int exp_bit);
        logic [FW-1:0] exp_data;
        bit            last;
        last = hdr[31];
        if (exp_bit < 0) model_err = 1'b1;
        strobe_bits.delete();
        strobe_data.delete();
        strobe_ready_hi = 0;
        done_cnt = 0;
        send_word(hdr, gap);
        for (int i = 0; i < NR; i++) begin
            words[i] = ramp ? W'(i) : $urandom;
            send_word(words[i], gap);
        end
        for (int r = 0; r < NR; r++) exp_data[r*W +: W] = words[NR-1-r];
        step();
        step();
        chk("strobe_count", 64'(strobe_bits.size()), (exp_bit >= 0) ? 64'd1 : 64'd0);
        if (exp_bit >= 0 && strobe_bits.size() == 1) begin
            chk("strobe_bit", 64'(strobe_bits[0]), 64'(exp_bit));
            chk_data("data_at_strobe", strobe_data[0], exp_data);
        end
        chk("ready_during_strobe", 64'(strobe_ready_hi), 64'd0);
        chk_data("data_held", FrameData, exp_data);
        chk("strobe_idle", 64'(FrameStrobe != '0), 64'd0);
        chk("done_pulses", 64'(done_cnt), 64'(last));
        chk("active_after_frame", 64'(cfg_active), 64'(!last));
        chk("err_after_frame", 64'(cfg_err), 64'(model_err));
        $display("[TB] frame hdr=%h exp_bit=%0d strobes=%0d err=%0b", hdr, exp_bit, strobe_bits.size(), cfg_err);
    endtask

    typedef struct {
        logic [W-1:0] hdr;
        int           exp_bit;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h8000_0000, 0};
        vecs[1] = '{32'h8000_0F13, 319};
        vecs[2] = '{32'h8000_0013, 19};
        vecs[3] = '{32'h8000_0F00, 300};
        vecs[4] = '{32'h8000_1000, -1};
        vecs[5] = '{32'h8000_0014, -1};
        vecs[6] = '{32'hFAB0_FAB1, -1};
        vecs[7] = '{32'h807F_0AE7, 207};
        vecs[8] = '{32'h8000_FF1F, -1};

        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_ready", 64'(s_ready), 64'd1);
        chk_data("rst_data", FrameData, '0);
        chk("rst_strobe", 64'(FrameStrobe != '0), 64'd0);
        chk("rst_active", 64'(cfg_active), 64'd0);
        chk("rst_done", 64'(cfg_done), 64'd0);
        chk("rst_err", 64'(cfg_err), 64'd0);

        // Junk before sync is discarded; sync raises cfg_active next cycle.
        send_word(32'h1234_5678, 0);
        chk("junk_no_active", 64'(cfg_active), 64'd0);
        send_word(SYNC_WORD, 0);
        chk("sync_active", 64'(cfg_active), 64'd1);
        model_err = 1'b0;
        run_frame(32'h8000_0305, 1'b1, 0, 65);
        chk("row15_first_word", 64'(FrameData[15*W +: W]), 64'd0);
        chk("row0_last_word", 64'(FrameData[0 +: W]), 64'd15);

        for (int v = 0; v < 9; v++) begin
            send_word(SYNC_WORD, 1);
            model_err = 1'b0;
            chk("sync_clears_err", 64'(cfg_err), 64'd0);
            run_frame(vecs[v].hdr, 1'b0, 0, vecs[v].exp_bit);
            if (vecs[v].exp_bit < 0) begin
                send_word(32'h0000_0001, 0);
                repeat (3) step();
                chk("err_sticky", 64'(cfg_err), 64'd1);
            end
        end

        // Two frames in one session with random valid gaps.
        send_word(SYNC_WORD, 2);
        model_err = 1'b0;
        run_frame(32'h0000_0000, 1'b0, 3, 0);
        run_frame(32'h8000_0F13, 1'b0, 3, 319);

        // Reset after 7 of 16 data words: nothing strobed, data cleared.
        strobe_bits.delete();
        send_word(SYNC_WORD, 0);
        send_word(32'h8000_0305, 0);
        for (int i = 0; i < 7; i++) send_word($urandom, 0);
        reset = 1'b1;
        step();
        chk_data("midrst_data", FrameData, '0);
        chk("midrst_strobe", 64'(FrameStrobe != '0), 64'd0);
        chk("midrst_active", 64'(cfg_active), 64'd0);
        chk("midrst_ready", 64'(s_ready), 64'd1);
        reset = 1'b0;
        repeat (20) step();
        chk("midrst_no_strobe", 64'(strobe_bits.size()), 64'd0);
        send_word(SYNC_WORD, 0);
        model_err = 1'b0;
        run_frame(32'h8000_0305, 1'b0, 1, 65);

        // Randomized sessions against the header-parsing model.
        for (int s = 0; s < 12; s++) begin
            int nfr;
            if ($urandom_range(1, 0) == 1) send_word($urandom | 32'h1, 1);
            send_word(SYNC_WORD, 2);
            model_err = 1'b0;
            nfr = int'($urandom_range(3, 1));
            for (int f = 0; f < nfr; f++) begin
                int           col;
                int           frm;
                int           exp;
                logic [W-1:0] hdr;
                col = int'($urandom_range(17, 0));
                frm = int'($urandom_range(21, 0));
                hdr = {(f == nfr - 1), 15'($urandom), 8'(col), 3'($urandom), 5'(frm)};
                exp = (col < NC && frm < MF) ? col * MF + frm : -1;
                run_frame(hdr, 1'b0, int'($urandom_range(2, 0)), exp);
            end
        end

        chk("done_timing", 64'(done_bad), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
